control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Micro-op decoder and sequencer for the 8-bit accumulator CPU.
- Inputs: the 3-bit step count from the step counter, the current opcode from the instruction register, and the ALU flags.
- Outputs: the one-hot-per-function control word for the bus and registers, plus the step-counter reset that ends each instruction.
- Owns the halt state, an illegal-opcode trap and a retired-instruction counter.

Parameters:
- INSTR_CNT_WIDTH, 16, width of the retired-instruction counter; wraps modulo 2^INSTR_CNT_WIDTH.
- MAX_STEP, 4, highest legal step index; any Step > MAX_STEP is a fault step.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- Step  input  3  current T-state from the step counter; 0 after reset or after the counter is cleared.
- Opcode  input  4  IR[7:4].
- CarryFlag  input  1  registered ALU carry.
- ZeroFlag  input  1  registered ALU zero.
- PcOut, PcInc, PcLoad  output  1 each  program counter: drive bus / increment / load from bus.
- MarIn  output  1  memory address register loads from bus.
- RamOut, RamIn  output  1 each  RAM drives bus / RAM writes from bus.
- IrIn, IrOut  output  1 each  IR loads from bus / IR[3:0] drives bus.
- AIn, AOut, BIn  output  1 each  A register load, A register drive, B register load.
- AluOut, AluSub, FlagsIn  output  1 each  ALU drives bus, subtract select, flags latch.
- OutIn  output  1  output register loads from bus.
- StepCounterReset  output  1  step counter returns to 0 on the next Clk.
- Halted  output  1  sticky halt state.
- IllegalOp  output  1  sticky illegal-opcode flag.
- InstrCount  output  INSTR_CNT_WIDTH  retired-instruction count.

Behaviour:
- Control outputs are combinational from Step, Opcode, flags and Halted. Every output not listed for a step is 0.
- Fetch, all opcodes:
  - T0: PcOut, MarIn.
  - T1: RamOut, IrIn, PcInc.
- Execute, StepCounterReset asserted in each opcode's final step:
  - 0 NOP: T2 SCR.
  - 1 LDA: T2 IrOut, MarIn. T3 RamOut, AIn, SCR.
  - 2 ADD: T2 IrOut, MarIn. T3 RamOut, BIn. T4 AluOut, AIn, FlagsIn, SCR.
  - 3 SUB: same as ADD, with AluSub asserted in both T3 and T4.
  - 4 STA: T2 IrOut, MarIn. T3 AOut, RamIn, SCR.
  - 5 LDI: T2 IrOut, AIn, SCR.
  - 6 JMP: T2 IrOut, PcLoad, SCR.
  - 7 JC: T2 IrOut, SCR; PcLoad only if CarryFlag=1.
  - 8 JZ: T2 IrOut, SCR; PcLoad only if ZeroFlag=1.
  - E OUT: T2 AOut, OutIn, SCR.
  - F HLT: T2 SCR. Halted<=1 at the end of that cycle.
  - 9–D (illegal): behave as NOP (see Optional Feature).
- Fault step: Step > MAX_STEP, caused by an opcode change mid-instruction. Output is SCR only, all other controls 0, InstrCount not incremented.
- Halted=1:
  - All controls 0 except StepCounterReset=1, which holds Step at 0.
  - Halted is cleared only by Rst.
- InstrCount increments by 1 on each rising edge where StepCounterReset=1, Halted=0, and Step <= MAX_STEP. The HLT instruction counts as retired.
- Reset values: Halted=0, IllegalOp=0, InstrCount=0.
  - After reset Step=0, so PcOut=MarIn=1 in the first post-reset cycle.
  - Rst mid-instruction abandons that instruction without incrementing InstrCount.
  - Rst has priority over the HLT set and the counter increment in the same cycle.
- Latency: fetch is 2 cycles. Instruction totals are NOP/LDI/JMP/JC/JZ/OUT/HLT = 3, LDA/STA = 4, ADD/SUB = 5.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode at T2 asserts SCR only, and sets IllegalOp=1 and Halted=1 at the end of that cycle. The instruction is not counted. Both flags are cleared only by Rst.
- Undefined: illegal opcodes execute as NOP and are counted; IllegalOp is tied to 0.

Test Plan:
- Rst, then Step=0 → PcOut=MarIn=1, all else 0; Halted=0, InstrCount=0.
- Opcode=2 (ADD), Step 0..4 → T3 RamOut+BIn+AluSub=0; T4 AluOut+AIn+FlagsIn+SCR; InstrCount 0→1.
- Opcode=7 (JC) at T2: CarryFlag=0 → PcLoad=0, SCR=1. Repeat with CarryFlag=1 → PcLoad=1. InstrCount +1 each.
- Opcode=F (HLT) at T2 → Halted=1 next cycle; SCR held at 1 and all controls 0 for 10 cycles; InstrCount frozen. Rst → Halted=0, InstrCount=0.
- Opcode=1 at T2, then switch to 5 at T3; force Step=6 → SCR=1 only, InstrCount unchanged.
- Opcode=A at T2:
  - With CTRL_ILLEGAL_TRAP_EN → IllegalOp=1, Halted=1, count unchanged.
  - Without it → NOP behaviour, count +1, IllegalOp=0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Bus between the step counter / instruction register side of the CPU and
// the micro-op sequencer. The master modport belongs to whoever drives Step,
// Opcode and the ALU flags. The slave modport belongs to the sequencer, which
// drives the control word and its status outputs.
interface control_sequencer_if #(
   parameter int INSTR_CNT_WIDTH = 16
);

   logic [2:0]                 Step;
   logic [3:0]                 Opcode;
   logic                       CarryFlag;
   logic                       ZeroFlag;

   logic                       PcOut;
   logic                       PcInc;
   logic                       PcLoad;
   logic                       MarIn;
   logic                       RamOut;
   logic                       RamIn;
   logic                       IrIn;
   logic                       IrOut;
   logic                       AIn;
   logic                       AOut;
   logic                       BIn;
   logic                       AluOut;
   logic                       AluSub;
   logic                       FlagsIn;
   logic                       OutIn;
   logic                       StepCounterReset;
   logic                       Halted;
   logic                       IllegalOp;
   logic [INSTR_CNT_WIDTH-1:0] InstrCount;

   modport master (
      output Step, Opcode, CarryFlag, ZeroFlag,
      input  PcOut, PcInc, PcLoad, MarIn, RamOut, RamIn, IrIn, IrOut,
             AIn, AOut, BIn, AluOut, AluSub, FlagsIn, OutIn,
             StepCounterReset, Halted, IllegalOp, InstrCount
   );

   modport slave (
      input  Step, Opcode, CarryFlag, ZeroFlag,
      output PcOut, PcInc, PcLoad, MarIn, RamOut, RamIn, IrIn, IrOut,
             AIn, AOut, BIn, AluOut, AluSub, FlagsIn, OutIn,
             StepCounterReset, Halted, IllegalOp, InstrCount
   );

endinterface

// File: rtl/control_sequencer.sv
// Micro-op decoder and sequencer for the 8-bit accumulator CPU.
// The control word is decoded combinationally from Step, Opcode, the ALU
// flags and the halt state. The sequencer also owns the sticky halt state,
// the retired-instruction counter and, optionally, an illegal-opcode trap.
//
// Optional feature: when CTRL_ILLEGAL_TRAP_EN is defined, opcodes 9..D halt
// the CPU at T2 and set IllegalOp. When it is undefined, they run as NOP and
// IllegalOp is held at 0.
// INSTR_CNT_WIDTH must match the parameter of the connected interface.
module control_sequencer #(
   parameter int INSTR_CNT_WIDTH = 16,
   parameter int MAX_STEP        = 4
) (
   input logic          Clk,
   input logic          Rst,
   control_sequencer_if.slave bus
);

   localparam logic [2:0] MaxStepL = 3'(MAX_STEP);

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpLda = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpSta = 4'h4;
   localparam logic [3:0] OpLdi = 4'h5;
   localparam logic [3:0] OpJmp = 4'h6;
   localparam logic [3:0] OpJc  = 4'h7;
   localparam logic [3:0] OpJz  = 4'h8;
   localparam logic [3:0] OpOut = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } state_e;

   state_e                     state_q, state_d;
   logic [INSTR_CNT_WIDTH-1:0] instrCount_q, instrCount_d;
   logic                       scr;
   logic                       faultStep;
   logic                       haltReq;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic                       illegalOp_q, illegalOp_d;
   logic                       trapHit;
`endif

   // Decode the control word for the current step.
   // This block also works out the next halt state and the next retired count.
   always_comb begin
      bus.PcOut    = 1'b0;
      bus.PcInc    = 1'b0;
      bus.PcLoad   = 1'b0;
      bus.MarIn    = 1'b0;
      bus.RamOut   = 1'b0;
      bus.RamIn    = 1'b0;
      bus.IrIn     = 1'b0;
      bus.IrOut    = 1'b0;
      bus.AIn      = 1'b0;
      bus.AOut     = 1'b0;
      bus.BIn      = 1'b0;
      bus.AluOut   = 1'b0;
      bus.AluSub   = 1'b0;
      bus.FlagsIn  = 1'b0;
      bus.OutIn    = 1'b0;
      scr          = 1'b0;
      haltReq      = 1'b0;
      faultStep    = (bus.Step > MaxStepL);
      state_d      = state_q;
      instrCount_d = instrCount_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trapHit      = 1'b0;
      illegalOp_d  = illegalOp_q;
`endif

      if (state_q == ST_HALT) begin
         scr = 1'b1;
      end else if (faultStep) begin
         scr = 1'b1;
      end else begin
         case (bus.Step)
            3'd0: begin
               bus.PcOut = 1'b1;
               bus.MarIn = 1'b1;
            end
            3'd1: begin
               bus.RamOut = 1'b1;
               bus.IrIn   = 1'b1;
               bus.PcInc  = 1'b1;
            end
            3'd2: begin
               case (bus.Opcode)
                  OpNop: scr = 1'b1;
                  OpLda, OpAdd, OpSub, OpSta: begin
                     bus.IrOut = 1'b1;
                     bus.MarIn = 1'b1;
                  end
                  OpLdi: begin
                     bus.IrOut = 1'b1;
                     bus.AIn   = 1'b1;
                     scr       = 1'b1;
                  end
                  OpJmp: begin
                     bus.IrOut  = 1'b1;
                     bus.PcLoad = 1'b1;
                     scr        = 1'b1;
                  end
                  OpJc: begin
                     bus.IrOut  = 1'b1;
                     bus.PcLoad = bus.CarryFlag;
                     scr        = 1'b1;
                  end
                  OpJz: begin
                     bus.IrOut  = 1'b1;
                     bus.PcLoad = bus.ZeroFlag;
                     scr        = 1'b1;
                  end
                  OpOut: begin
                     bus.AOut  = 1'b1;
                     bus.OutIn = 1'b1;
                     scr       = 1'b1;
                  end
                  OpHlt: begin
                     scr     = 1'b1;
                     haltReq = 1'b1;
                  end
                  default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                     trapHit = 1'b1;
                     haltReq = 1'b1;
`endif
                     scr     = 1'b1;
                  end
               endcase
            end
            3'd3: begin
               case (bus.Opcode)
                  OpLda: begin
                     bus.RamOut = 1'b1;
                     bus.AIn    = 1'b1;
                     scr        = 1'b1;
                  end
                  OpAdd, OpSub: begin
                     bus.RamOut = 1'b1;
                     bus.BIn    = 1'b1;
                     bus.AluSub = (bus.Opcode == OpSub);
                  end
                  OpSta: begin
                     bus.AOut  = 1'b1;
                     bus.RamIn = 1'b1;
                     scr       = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd4: begin
               if (bus.Opcode == OpAdd || bus.Opcode == OpSub) begin
                  bus.AluOut  = 1'b1;
                  bus.AIn     = 1'b1;
                  bus.FlagsIn = 1'b1;
                  bus.AluSub  = (bus.Opcode == OpSub);
                  scr         = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (state_q == ST_RUN && !faultStep && scr) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         if (!trapHit) begin
            instrCount_d = instrCount_q + 1'b1;
         end
`else
         instrCount_d = instrCount_q + 1'b1;
`endif
      end

      if (haltReq) begin
         state_d = ST_HALT;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (trapHit) begin
         illegalOp_d = 1'b1;
      end
`endif

      bus.StepCounterReset = scr;
   end

   // Update the halt state, the trap flag and the retired count.
   // Reset takes priority over halting and counting in the same cycle.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= ST_RUN;
         instrCount_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegalOp_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         instrCount_q <= instrCount_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegalOp_q  <= illegalOp_d;
`endif
      end
   end

   assign bus.Halted     = (state_q == ST_HALT);
   assign bus.InstrCount = instrCount_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign bus.IllegalOp  = illegalOp_q;
`else
   assign bus.IllegalOp  = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard testbench for control_sequencer.
// The stimulus side drives one step per clock and pushes the expected
// response from a table-driven instruction model. A monitor on the falling
// edge pops each expected entry and compares it with the DUT outputs.
module tb_control_sequencer;

   localparam int CW = 16;

   localparam logic [15:0] M_PCOUT   = 16'h8000;
   localparam logic [15:0] M_PCINC   = 16'h4000;
   localparam logic [15:0] M_PCLOAD  = 16'h2000;
   localparam logic [15:0] M_MARIN   = 16'h1000;
   localparam logic [15:0] M_RAMOUT  = 16'h0800;
   localparam logic [15:0] M_RAMIN   = 16'h0400;
   localparam logic [15:0] M_IRIN    = 16'h0200;
   localparam logic [15:0] M_IROUT   = 16'h0100;
   localparam logic [15:0] M_AIN     = 16'h0080;
   localparam logic [15:0] M_AOUT    = 16'h0040;
   localparam logic [15:0] M_BIN     = 16'h0020;
   localparam logic [15:0] M_ALUOUT  = 16'h0010;
   localparam logic [15:0] M_ALUSUB  = 16'h0008;
   localparam logic [15:0] M_FLAGSIN = 16'h0004;
   localparam logic [15:0] M_OUTIN   = 16'h0002;
   localparam logic [15:0] M_SCR     = 16'h0001;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef struct {
      bit            check;
      logic [15:0]   ctrl;
      logic          halted;
      logic          illegal;
      logic [CW-1:0] count;
      string         tag;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst;

   control_sequencer_if #(.INSTR_CNT_WIDTH(CW)) bus ();

   control_sequencer #(
      .INSTR_CNT_WIDTH(CW),
      .MAX_STEP(4)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus.slave)
   );

   exp_t          expQ[$];
   logic [15:0]   ucode [0:15][0:4];
   int            instrLen [0:15];
   logic          mHalted;
   logic          mIllegal;
   logic [CW-1:0] mCount;
   int            tests = 0;
   int            fails = 0;

   // Free-running clock with a 10-unit period.
   always #5 Clk = ~Clk;

   // Build the micro-op table. Each opcode lists the micro-ops for every
   // step. The model adds StepCounterReset at the last step of each opcode.
   task automatic buildTables();
      for (int op = 0; op < 16; op++) begin
         instrLen[op] = 3;
         ucode[op][0] = M_PCOUT | M_MARIN;
         ucode[op][1] = M_RAMOUT | M_IRIN | M_PCINC;
         for (int s = 2; s < 5; s++) ucode[op][s] = 16'h0;
      end
      ucode[1][2] = M_IROUT | M_MARIN;   ucode[1][3] = M_RAMOUT | M_AIN;   instrLen[1] = 4;
      ucode[2][2] = M_IROUT | M_MARIN;   ucode[2][3] = M_RAMOUT | M_BIN;
      ucode[2][4] = M_ALUOUT | M_AIN | M_FLAGSIN;                         instrLen[2] = 5;
      ucode[3][2] = M_IROUT | M_MARIN;   ucode[3][3] = M_RAMOUT | M_BIN | M_ALUSUB;
      ucode[3][4] = M_ALUOUT | M_AIN | M_FLAGSIN | M_ALUSUB;              instrLen[3] = 5;
      ucode[4][2] = M_IROUT | M_MARIN;   ucode[4][3] = M_AOUT | M_RAMIN;   instrLen[4] = 4;
      ucode[5][2] = M_IROUT | M_AIN;
      ucode[6][2] = M_IROUT | M_PCLOAD;
      ucode[7][2] = M_IROUT;
      ucode[8][2] = M_IROUT;
      ucode[14][2] = M_AOUT | M_OUTIN;
   endtask

   function automatic bit isIllegal(input logic [3:0] op);
      return (op >= 4'h9) && (op <= 4'hD);
   endfunction

   // Drive one clock's worth of inputs and push the expected response.
   // Then advance the model state past the next rising edge.
   task automatic applyStimulus(input logic [2:0] step, input logic [3:0] op,
                                input logic c, input logic z, input logic rst,
                                input bit check, input string tag);
      exp_t e;
      bit   lastStep;
      bit   trapped;
      @(posedge Clk);
      #1;
      Rst           = rst;
      bus.Step      = step;
      bus.Opcode    = op;
      bus.CarryFlag = c;
      bus.ZeroFlag  = z;

      lastStep = (int'(step) <= 4) && (int'(step) == instrLen[op] - 1);
      trapped  = TRAP_EN && isIllegal(op) && (step == 3'd2);

      e.check   = check;
      e.tag     = tag;
      e.halted  = mHalted;
      e.illegal = mIllegal;
      e.count   = mCount;
      if (mHalted || int'(step) > 4) begin
         e.ctrl = M_SCR;
      end else begin
         e.ctrl = ucode[op][step];
         if (step == 3'd2 && op == 4'h7 && c) e.ctrl = e.ctrl | M_PCLOAD;
         if (step == 3'd2 && op == 4'h8 && z) e.ctrl = e.ctrl | M_PCLOAD;
         if (lastStep) e.ctrl = e.ctrl | M_SCR;
      end
      expQ.push_back(e);

      if (rst) begin
         mHalted  = 1'b0;
         mIllegal = 1'b0;
         mCount   = '0;
      end else if (!mHalted && lastStep) begin
         if (!trapped) mCount = mCount + 1'b1;
         if (op == 4'hF || trapped) mHalted = 1'b1;
         if (trapped) mIllegal = 1'b1;
      end
   endtask

   // Run a whole instruction. A non-negative abortAt asserts Rst at that
   // step instead, which abandons the instruction.
   task automatic runInstr(input logic [3:0] op, input logic c, input logic z,
                           input int abortAt, input string tag);
      for (int s = 0; s < instrLen[op]; s++) begin
         if (s == abortAt) begin
            applyStimulus(3'(s), op, c, z, 1'b1, 1'b1, "abort");
            return;
         end
         applyStimulus(3'(s), op, c, z, 1'b0, 1'b1, tag);
      end
   endtask

   // Hold the halted CPU for n cycles with Step pinned at 0, then reset.
   task automatic haltThenReset(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(3'd0, 4'($urandom_range(0, 15)), 1'($urandom),
                       1'($urandom), 1'b0, 1'b1, "halted");
      end
      applyStimulus(3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, "halt-rst");
   endtask

   task automatic checkOutput(input exp_t e);
      logic [15:0] act;
      act = {bus.PcOut, bus.PcInc, bus.PcLoad, bus.MarIn, bus.RamOut, bus.RamIn,
             bus.IrIn, bus.IrOut, bus.AIn, bus.AOut, bus.BIn, bus.AluOut,
             bus.AluSub, bus.FlagsIn, bus.OutIn, bus.StepCounterReset};
      tests++;
      if (act !== e.ctrl) begin
         fails++;
         $display("[TB] FAIL %s ctrl: got %h expected %h", e.tag, act, e.ctrl);
      end
      tests++;
      if ({bus.Halted, bus.IllegalOp} !== {e.halted, e.illegal}) begin
         fails++;
         $display("[TB] FAIL %s halted/illegal: got %b%b expected %b%b",
                  e.tag, bus.Halted, bus.IllegalOp, e.halted, e.illegal);
      end
      tests++;
      if (bus.InstrCount !== e.count) begin
         fails++;
         $display("[TB] FAIL %s count: got %0d expected %0d",
                  e.tag, bus.InstrCount, e.count);
      end
   endtask

   // Monitor: on each falling edge, pop one expected entry and compare it
   // with what the DUT presents.
   always @(negedge Clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         if (e.check) checkOutput(e);
      end
   end

   // Stimulus: directed cases first, then randomized instruction streams.
   initial begin
      int op;
      int abortAt;
      buildTables();
      mHalted  = 1'b0;
      mIllegal = 1'b0;
      mCount   = '0;
      Rst           = 1'b1;
      bus.Step      = 3'd0;
      bus.Opcode    = 4'h0;
      bus.CarryFlag = 1'b0;
      bus.ZeroFlag  = 1'b0;

      applyStimulus(3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, "rst0");
      applyStimulus(3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, "rst1");
      applyStimulus(3'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, "post-rst");

      runInstr(4'h2, 1'b0, 1'b0, 1, "add-tail");
      runInstr(4'h2, 1'b1, 1'b0, -1, "add");
      runInstr(4'h3, 1'b0, 1'b1, -1, "sub");
      runInstr(4'h7, 1'b0, 1'b1, -1, "jc-c0");
      runInstr(4'h7, 1'b1, 1'b0, -1, "jc-c1");
      runInstr(4'h8, 1'b0, 1'b0, -1, "jz-z0");
      runInstr(4'h8, 1'b0, 1'b1, -1, "jz-z1");

      applyStimulus(3'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, "fault-t0");
      applyStimulus(3'd1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, "fault-t1");
      applyStimulus(3'd2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, "fault-t2");
      applyStimulus(3'd3, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, "fault-t3");
      applyStimulus(3'd6, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, "fault-t6");
      applyStimulus(3'd7, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, "fault-t7");

      runInstr(4'hA, 1'b0, 1'b0, -1, "illegal-a");
      if (mHalted) haltThenReset(3);

      runInstr(4'hE, 1'b0, 1'b0, -1, "out");
      runInstr(4'hF, 1'b0, 1'b0, -1, "hlt");
      haltThenReset(10);

      for (int n = 0; n < 200; n++) begin
         op      = int'($urandom_range(0, 15));
         abortAt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
         runInstr(4'(op), 1'($urandom), 1'($urandom), abortAt, "rand");
         if (mHalted) haltThenReset(int'($urandom_range(1, 10)));
      end

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge Clk);
      @(posedge Clk);
      tests++;
      if (expQ.size() != 0) begin
         fails++;
         $display("[TB] FAIL drain: got %0d entries pending expected 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
